// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-file bus arbiter: address map, sequencer
// states, the latched request record and address-map helpers.
package reg_bus_pkg;

    localparam logic [2:0] ADDR_CNAME   = 3'd0;
    localparam logic [2:0] ADDR_CVER    = 3'd1;
    localparam logic [2:0] ADDR_TRI     = 3'd2;
    localparam logic [2:0] ADDR_PIN     = 3'd3;
    localparam logic [2:0] ADDR_IMASK   = 3'd4;
    localparam logic [2:0] ADDR_DATA    = 3'd5;
    localparam logic [2:0] ADDR_SCRATCH = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } bus_state_e;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [2:0]  addr;
        logic [3:0]  wben;
        logic [31:0] wdata;
        logic        err;
    } bus_req_t;

    function automatic logic is_mapped(input logic [2:0] addr);
        return addr != 3'b111;
    endfunction

    // Chip name, chip version and the pin-state register are read-only.
    function automatic logic is_writable(input logic [2:0] addr);
        return is_mapped(addr) && (addr != ADDR_CNAME) &&
               (addr != ADDR_CVER) && (addr != ADDR_PIN);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way request picker with a round-robin "last granted" pointer and an
// optional fixed-priority override where port 0 always wins a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie the port that was not served last goes next.
            2'b11:   gnt = (fixed || last) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Arbitrates two requesters onto the single register-file port, filters
// unmapped / read-only accesses and returns a registered response per port.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_i,
    input  logic        we0,
    input  logic        we1,
    input  logic [4:2]  addr0,
    input  logic [4:2]  addr1,
    input  logic [3:0]  wben0,
    input  logic [3:0]  wben1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  gnt_o,
    output logic [1:0]  rvalid_o,
    output logic [1:0]  rerr_o,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [4:2]  rf_addr,
    output logic [3:0]  rf_wben,
    output logic        rf_r_wn,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata
);

    bus_state_e  state_q;
    logic        last_q;
    bus_req_t    req_q;
    bus_req_t    req_d;
    logic [1:0]  pick;
    logic [1:0]  rvalid_q;
    logic [1:0]  rerr_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;
    logic [2:0]  rf_addr_q;
    logic [3:0]  rf_wben_q;
    logic        rf_r_wn_q;
    logic [31:0] rf_wdata_q;
    logic [31:0] resp_data_d;

    rr_arb2 u_arb (
        .req   (req_i),
        .last  (last_q),
        .fixed (PRIO_FIXED),
        .gnt   (pick)
    );

    assign gnt_o = (state_q == ST_IDLE) ? pick : 2'b00;

    // Payload of whichever port wins this cycle, with its access check.
    always_comb begin
        req_d       = '0;
        req_d.port  = pick[1];
        req_d.we    = pick[1] ? we1    : we0;
        req_d.addr  = pick[1] ? addr1  : addr0;
        req_d.wben  = pick[1] ? wben1  : wben0;
        req_d.wdata = pick[1] ? wdata1 : wdata0;
        req_d.err   = !is_mapped(req_d.addr) ||
                      (req_d.we && !is_writable(req_d.addr));
    end

    assign resp_data_d = (!req_q.err && !req_q.we) ? rf_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            req_q      <= '0;
            rvalid_q   <= 2'b00;
            rerr_q     <= 2'b00;
            rdata0_q   <= 32'd0;
            rdata1_q   <= 32'd0;
            rf_addr_q  <= 3'd0;
            rf_wben_q  <= 4'd0;
            rf_r_wn_q  <= 1'b1;
            rf_wdata_q <= 32'd0;
        end else begin
            rvalid_q   <= 2'b00;
            rerr_q     <= 2'b00;
            // Idle bus is a harmless read of the chip-name register.
            rf_addr_q  <= 3'd0;
            rf_wben_q  <= 4'd0;
            rf_r_wn_q  <= 1'b1;
            rf_wdata_q <= 32'd0;
            case (state_q)
                ST_IDLE: begin
                    if (|pick) begin
                        req_q  <= req_d;
                        last_q <= pick[1];
                        if (req_d.err) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q    <= ST_ISSUE;
                            rf_addr_q  <= req_d.addr;
                            rf_r_wn_q  <= !req_d.we;
                            rf_wben_q  <= req_d.we ? req_d.wben  : 4'd0;
                            rf_wdata_q <= req_d.we ? req_d.wdata : 32'd0;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    state_q  <= ST_IDLE;
                    rvalid_q <= req_q.port ? 2'b10 : 2'b01;
                    rerr_q   <= req_q.err ? (req_q.port ? 2'b10 : 2'b01) : 2'b00;
                    if (req_q.port) begin
                        rdata1_q <= resp_data_d;
                    end else begin
                        rdata0_q <= resp_data_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rvalid_o = rvalid_q;
    assign rerr_o   = rerr_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign rf_addr  = rf_addr_q;
    assign rf_wben  = rf_wben_q;
    assign rf_r_wn  = rf_r_wn_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters, each in front of a
// small behavioural register file, driven by the same request stimulus.
module tb_reg_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic        we0;
    logic        we1;
    logic [4:2]  addr0;
    logic [4:2]  addr1;
    logic [3:0]  wben0;
    logic [3:0]  wben1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;

    int tests_run    = 0;
    int tests_failed = 0;
    int wr_cycles    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [1:0]  gnt;
        logic [1:0]  rvalid;
        logic [1:0]  rerr;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [4:2]  rf_addr;
        logic [3:0]  rf_wben;
        logic        rf_r_wn;
        logic [31:0] rf_wdata;
        logic [31:0] rd_q;
        logic [31:0] regs [8];

        reg_bus_arbiter #(.PRIO_FIXED(gi)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .req_i    (req),
            .we0      (we0),
            .we1      (we1),
            .addr0    (addr0),
            .addr1    (addr1),
            .wben0    (wben0),
            .wben1    (wben1),
            .wdata0   (wdata0),
            .wdata1   (wdata1),
            .gnt_o    (gnt),
            .rvalid_o (rvalid),
            .rerr_o   (rerr),
            .rdata0   (rd0),
            .rdata1   (rd1),
            .rf_addr  (rf_addr),
            .rf_wben  (rf_wben),
            .rf_r_wn  (rf_r_wn),
            .rf_wdata (rf_wdata),
            .rf_rdata (rd_q)
        );

        // Register file: writes commit and reads register at the clock edge.
        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < 8; i++) regs[i] <= 32'd0;
                rd_q <= 32'd0;
            end else begin
                if (!rf_r_wn) begin
                    for (int b = 0; b < 4; b++)
                        if (rf_wben[b]) regs[rf_addr][8*b +: 8] <= rf_wdata[8*b +: 8];
                end
                rd_q <= (rf_addr == 3'd0) ? 32'h48524a44 :
                        (rf_addr == 3'd1) ? 32'h00010000 :
                        (rf_addr == 3'd7) ? 32'd0 : regs[rf_addr];
            end
        end
    end

    always @(negedge clk) begin
        if (g_inst[0].rf_r_wn === 1'b0) wr_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One transaction from an idle bus; checks grant, bus activity and response.
    task automatic xact(input int p, input logic we, input logic [2:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
        logic [1:0] pm;
        int n;
        pm = (p == 0) ? 2'b01 : 2'b10;
        if (p == 0) begin
            we0 = we; addr0 = a; wben0 = be; wdata0 = wd;
        end else begin
            we1 = we; addr1 = a; wben1 = be; wdata1 = wd;
        end
        req = pm;
        #1;
        n = 0;
        while (g_inst[0].gnt !== pm && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check("gnt", g_inst[0].gnt, pm);
        check("gnt_wait", n, 0);
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk);
        if (!exp_err) begin
            check("rf_r_wn", g_inst[0].rf_r_wn, !we);
            check("rf_addr", g_inst[0].rf_addr, a);
            check("rf_wben", g_inst[0].rf_wben, we ? be : 4'd0);
            check("rf_wdata", g_inst[0].rf_wdata, we ? wd : 32'd0);
        end else begin
            check("err_rf_r_wn", g_inst[0].rf_r_wn, 1'b1);
        end
        n = 1;
        while (g_inst[0].rvalid === 2'b00 && n < 6) begin
            @(negedge clk); n++;
        end
        check("latency", n, exp_err ? 2 : 3);
        check("rvalid", g_inst[0].rvalid, pm);
        check("rerr", g_inst[0].rerr, exp_err ? pm : 2'b00);
        check("rdata", (p == 0) ? g_inst[0].rd0 : g_inst[0].rd1, exp_rd);
        $display("[TB] port%0d %s addr=%0d latency=%0d rerr=%b rdata=%h", p,
                 we ? "write" : "read", a, n, g_inst[0].rerr, (p == 0) ? g_inst[0].rd0 : g_inst[0].rd1);
        @(negedge clk);
        check("rvalid_pulse", g_inst[0].rvalid, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [1:0] exp_rr;
        logic [1:0] exp_fx;
        reset = 1'b1; req = 2'b00;
        we0 = 1'b0; we1 = 1'b0; addr0 = 3'd0; addr1 = 3'd0;
        wben0 = 4'd0; wben1 = 4'd0; wdata0 = 32'd0; wdata1 = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_gnt", g_inst[0].gnt, 2'b00);
        check("rst_rvalid", g_inst[0].rvalid, 2'b00);
        check("rst_rerr", g_inst[0].rerr, 2'b00);
        check("rst_rdata0", g_inst[0].rd0, 32'd0);
        check("rst_rdata1", g_inst[0].rd1, 32'd0);
        check("rst_rf_r_wn", g_inst[0].rf_r_wn, 1'b1);
        check("rst_rf_addr", g_inst[0].rf_addr, 3'd0);
        check("rst_rf_wben", g_inst[0].rf_wben, 4'd0);
        check("rst_rf_wdata", g_inst[0].rf_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reads, writes and the rdata hold behaviour.
        xact(0, 1'b0, 3'd0, 4'h0, 32'd0, 1'b0, 32'h48524a44);
        check("rdata1_untouched", g_inst[0].rd1, 32'd0);
        w0 = wr_cycles;
        xact(1, 1'b1, 3'd6, 4'b0011, 32'hCAFEBABE, 1'b0, 32'd0);
        check("write_cycles", wr_cycles - w0, 1);
        xact(1, 1'b0, 3'd6, 4'h0, 32'd0, 1'b0, 32'h0000BABE);
        check("rdata0_hold", g_inst[0].rd0, 32'h48524a44);

        // Read-only write and unmapped read are rejected without bus activity.
        w0 = wr_cycles;
        xact(0, 1'b1, 3'd1, 4'hF, 32'h11111111, 1'b1, 32'd0);
        xact(0, 1'b0, 3'd7, 4'h0, 32'd0, 1'b1, 32'd0);
        check("err_no_write", wr_cycles - w0, 0);

        // Continuous contention: last grant went to port 0, so port 1 leads.
        we0 = 1'b0; addr0 = 3'd0; we1 = 1'b0; addr1 = 3'd6;
        req = 2'b11;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_rr = 2'b00;
            exp_fx = 2'b00;
            if (c % 3 == 0) begin
                exp_rr = ((c / 3) % 2 == 0) ? 2'b10 : 2'b01;
                exp_fx = 2'b01;
            end
            check("rr_gnt", g_inst[0].gnt, exp_rr);
            check("fixed_gnt", g_inst[1].gnt, exp_fx);
            @(negedge clk);
        end
        req = 2'b00;
        check("rr_rdata0", g_inst[0].rd0, 32'h48524a44);
        check("rr_rdata1", g_inst[0].rd1, 32'h0000BABE);
        $display("[TB] contention: 4 grants per instance checked");
        repeat (2) @(negedge clk);

        // Reset lands in the ISSUE cycle of a port-1 write to the data register.
        we1 = 1'b1; addr1 = 3'd5; wben1 = 4'hF; wdata1 = 32'h12345678;
        req = 2'b10;
        #1;
        check("rst_mid_gnt", g_inst[0].gnt, 2'b10);
        @(posedge clk); #1;
        req = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_issue", g_inst[0].rf_r_wn, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_rvalid", g_inst[0].rvalid, 2'b00);
        check("rst_mid_rerr", g_inst[0].rerr, 2'b00);
        check("rst_mid_rdata0", g_inst[0].rd0, 32'd0);
        check("rst_mid_rdata1", g_inst[0].rd1, 32'd0);
        check("rst_mid_rf_r_wn", g_inst[0].rf_r_wn, 1'b1);
        check("rst_mid_rf_addr", g_inst[0].rf_addr, 3'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_no_rvalid", g_inst[0].rvalid, 2'b00);
        end
        $display("[TB] reset during ISSUE: transaction dropped");
        xact(0, 1'b0, 3'd5, 4'h0, 32'd0, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Two-port arbiter and sequencer in front of the GPIO/ID register file (`register`). It accepts read/write requests from two requesters over a request/grant/response handshake: port 0 is the core load/store unit, port 1 is the debug/UART bridge. It serialises the requests onto the register file's single `addr`/`wben`/`r_wn`/`wdata` port and returns `rdata` to the winner. It also rejects accesses to unmapped or read-only addresses before they reach the register file.

## Interface
- `PRIO_FIXED`, default 0: 0 = round-robin between ports; 1 = port 0 always wins.
- `clk` in 1: master clock.
- `reset` in 1: synchronous, active-high.
- `req_i[1:0]` in 2: request per port.
- `we0`/`we1` in 1: 1 = write, 0 = read.
- `addr0`/`addr1` in 3 [4:2]: register address.
- `wben0`/`wben1` in 4: byte enables, writes only.
- `wdata0`/`wdata1` in 32: write data.
- `gnt_o[1:0]` out 2: one-cycle accept pulse per port.
- `rvalid_o[1:0]` out 2: one-cycle response pulse per port.
- `rerr_o[1:0]` out 2: error flag, valid with `rvalid`.
- `rdata0`/`rdata1` out 32: read data, valid with `rvalid`.
- `rf_addr` out 3 [4:2]: to register file.
- `rf_wben` out 4: to register file.
- `rf_r_wn` out 1: to register file; 1 = read.
- `rf_wdata` out 32: to register file.
- `rf_rdata` in 32: from register file.

## Operation
- A requester holds `req` and its payload stable until it sees `gnt`. `gnt` is combinational: asserted in the IDLE cycle in which that port wins.
- Arbitration:
  - Round-robin uses a `last` pointer. When both ports request, the port not granted last wins.
  - Reset value of `last` is 1, so port 0 wins the first tie.
  - With `PRIO_FIXED`=1, port 0 always wins a tie.
- On grant the block latches port, `we`, `addr`, `wben` and `wdata`, and sets the error flag:
  - Error on any access to address 3'b111.
  - Error on a write to 3'b000, 3'b001 or 3'b011 (read-only).
- FSM states:
  - IDLE: on grant, go to ISSUE if no error, else to RESP.
  - ISSUE: drive `rf_*` from the latch for exactly one cycle. A write drives `rf_r_wn`=0. Next state RESP.
  - RESP: if not an error and a read, capture `rf_rdata`. Next state IDLE.
- Response:
  - `rvalid`, `rdata` and `rerr` are registered on the RESP→IDLE edge.
  - Writes also get an `rvalid` pulse as the write acknowledge, with `rdata`=0.
  - Errors give `rvalid`=1, `rerr`=1, `rdata`=0, and produce no `rf_*` activity.
- Bus outside ISSUE: `rf_r_wn`=1, `rf_addr`=0, `rf_wben`=0, `rf_wdata`=0. This is a harmless read of the chip-name register and never a write.
- `rdata0`/`rdata1` hold their last value until the next response to that port.

## Timing
- Reset values: FSM=IDLE, `last`=1, `gnt_o`=0, `rvalid_o`=0, `rerr_o`=0, `rdata0`=`rdata1`=0. `rf_*` take the outside-ISSUE values above.
- Valid read, grant in cycle T:
  - T+1: ISSUE.
  - T+2: RESP. The register file's `rdata` is valid in this cycle and is captured at the end of it.
  - T+3: `rvalid` high.
  - T+3: a new grant is possible in the same cycle.
- Valid write: same timing. The register file commits at the end of T+1; `rvalid` at T+3.
- Error access:
  - T+1: RESP.
  - T+2: `rvalid`/`rerr` high.
- Throughput: 1 transaction per 3 cycles, or per 2 cycles for errors.
- `req` arriving while not in IDLE is held off with no `gnt`, and is served in the next IDLE cycle.
- Simultaneous `rvalid` (port A) and `gnt` (port B or A) in the same cycle is legal.
- Reset mid-operation: FSM returns to IDLE and the in-flight transaction is dropped with no `rvalid`. A write in ISSUE during the reset cycle is suppressed because the register file is also in reset.

## Structure
- Package `reg_bus_pkg`:
  - Address constants: `ADDR_CNAME`=0, `ADDR_CVER`=1, `ADDR_TRI`=2, `ADDR_PIN`=3, `ADDR_IMASK`=4, `ADDR_DATA`=5, `ADDR_SCRATCH`=6.
  - FSM state encoding: IDLE/ISSUE/RESP.
  - Functions `is_mapped(addr)` and `is_writable(addr)`.
- Sub-module `rr_arb2`: two-way picker. Inputs `req[1:0]`, `last`, `fixed`; outputs a one-hot grant. It is reusable by later bus bridges.

## Test plan
- Port 0 reads addr 0 from reset → `gnt_o`=01 at T, `rf_r_wn`=1 and `rf_addr`=0 at T+1, `rvalid_o`=01 and `rdata0`=32'h48524a44 at T+3.
- Port 1 writes addr 6, `wben`=4'b0011, `wdata`=32'hCAFEBABE, then reads it → exactly one cycle with `rf_r_wn`=0. Write ack `rvalid_o`=10; the read returns `rdata1` with [15:0]=16'hBABE.
- Both ports request continuously → grants alternate 01,10,01,… every 3 cycles. With `PRIO_FIXED`=1, only 01.
- Port 0 writes addr 1, then reads addr 7 → each gives `rvalid`+`rerr`=1 two cycles after `gnt`, `rdata0`=0, and `rf_r_wn` never drops.
- Assert `reset` in the ISSUE cycle of a port 1 write to addr 5 → no `rvalid`, FSM IDLE next cycle, all outputs at reset values, and the data register reads back 0.
